// File: rtl/spatz_pkg.sv
// Shared Spatz types: instruction IDs, vector register specifiers and the
// issue-scoreboard entry layout.
package spatz_pkg;

    localparam int unsigned NrParallelInstructions = 4;
    localparam int unsigned NrVregs = 32;

    typedef logic [$clog2(NrParallelInstructions)-1:0] spatz_id_t;
    typedef logic [$clog2(NrVregs)-1:0] vreg_t;

    typedef struct packed {
        logic  busy;
        logic  wr;
        logic  rd1;
        logic  rd2;
        logic  rdd;
        vreg_t vd;
        vreg_t vs1;
        vreg_t vs2;
    } sb_entry_t;

    // Index of each completion port on the scoreboard.
    typedef enum logic [1:0] {
        RET_VFU   = 2'd0,
        RET_VLSU  = 2'd1,
        RET_VSLDU = 2'd2
    } retire_port_e;

endpackage

// File: rtl/lzc.sv
// Trailing-zero counter: index of the lowest set bit, empty when no bit is set.
module lzc #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    always_comb begin
        cnt_o   = '0;
        empty_o = ~|in_i;
        // Scan downward so the lowest set bit is the last to be written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_i[i]) cnt_o = CNT_WIDTH'(i);
        end
    end

endmodule

// File: rtl/spatz_sb_hazard_check.sv
// Compares one scoreboard entry against the incoming issue payload and flags
// read-after-write, write-after-write and write-after-read conflicts.
module spatz_sb_hazard_check
    import spatz_pkg::*;
(
    input  sb_entry_t entry,
    input  vreg_t     vs1,
    input  vreg_t     vs2,
    input  vreg_t     vd,
    input  logic      use_vs1,
    input  logic      use_vs2,
    input  logic      use_vd,
    input  logic      vd_is_src,
    output logic      raw,
    output logic      waw,
    output logic      war
);

    logic src_vd;

    assign src_vd = use_vd && vd_is_src;

    assign raw = entry.busy && entry.wr &&
                 ((use_vs1 && (vs1 == entry.vd)) ||
                  (use_vs2 && (vs2 == entry.vd)) ||
                  (src_vd  && (vd  == entry.vd)));

    assign waw = entry.busy && entry.wr && use_vd && (vd == entry.vd);

    assign war = entry.busy && use_vd &&
                 ((entry.rd1 && (entry.vs1 == vd)) ||
                  (entry.rd2 && (entry.vs2 == vd)) ||
                  (entry.rdd && (entry.vd  == vd)));

endmodule

// File: rtl/spatz_issue_scoreboard.sv
// Issue scoreboard: hands out instruction IDs, tracks register usage of
// in-flight instructions and stalls issue on register hazards.
module spatz_issue_scoreboard
    import spatz_pkg::*;
#(
    parameter int unsigned NrIds         = NrParallelInstructions,
    parameter int unsigned NrRetirePorts = 3
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            issue_valid_i,
    output logic                            issue_ready_o,
    input  vreg_t                           issue_vs1_i,
    input  vreg_t                           issue_vs2_i,
    input  vreg_t                           issue_vd_i,
    input  logic                            issue_use_vs1_i,
    input  logic                            issue_use_vs2_i,
    input  logic                            issue_use_vd_i,
    input  logic                            issue_vd_is_src_i,
    output spatz_id_t                       issue_id_o,
    input  logic [NrRetirePorts-1:0]        retire_valid_i,
    input  spatz_id_t [NrRetirePorts-1:0]   retire_id_i,
    output logic [NrIds-1:0]                busy_o,
    output logic                            idle_o,
    output logic                            retire_err_o
);

    localparam int unsigned IdxW = (NrIds > 1) ? $clog2(NrIds) : 1;

    sb_entry_t [NrIds-1:0] entry_q, entry_d;
    logic [NrIds-1:0]      busy, busy_d, raw, waw, war;
    logic [IdxW-1:0]       free_idx;
    logic                  none_free;
    logic                  hazard;
    logic                  retire_err_d;
    logic                  idle_q;
    logic                  retire_err_q;

    for (genvar i = 0; i < NrIds; i++) begin : gen_entry
        assign busy[i] = entry_q[i].busy;

        spatz_sb_hazard_check i_hazard (
            .entry     (entry_q[i]),
            .vs1       (issue_vs1_i),
            .vs2       (issue_vs2_i),
            .vd        (issue_vd_i),
            .use_vs1   (issue_use_vs1_i),
            .use_vs2   (issue_use_vs2_i),
            .use_vd    (issue_use_vd_i),
            .vd_is_src (issue_vd_is_src_i),
            .raw       (raw[i]),
            .waw       (waw[i]),
            .war       (war[i])
        );
    end

    lzc #(
        .WIDTH     (NrIds),
        .CNT_WIDTH (IdxW)
    ) i_free_lzc (
        .in_i    (~busy),
        .cnt_o   (free_idx),
        .empty_o (none_free)
    );

    assign hazard        = |(raw | waw | war);
    assign issue_ready_o = !none_free && !hazard;
    assign issue_id_o    = none_free ? '0 : spatz_id_t'(free_idx);

    always_comb begin
        entry_d      = entry_q;
        retire_err_d = 1'b0;
        // Busy is checked against registered state, so two ports retiring the
        // same ID in one cycle free it once without flagging an error.
        for (int p = 0; p < NrRetirePorts; p++) begin
            if (retire_valid_i[p]) begin
                if (entry_q[retire_id_i[p]].busy) entry_d[retire_id_i[p]].busy = 1'b0;
                else retire_err_d = 1'b1;
            end
        end
        if (issue_valid_i && issue_ready_o) begin
            entry_d[issue_id_o] = sb_entry_t'{
                busy: 1'b1,
                wr:   issue_use_vd_i,
                rd1:  issue_use_vs1_i,
                rd2:  issue_use_vs2_i,
                rdd:  issue_use_vd_i && issue_vd_is_src_i,
                vd:   issue_vd_i,
                vs1:  issue_vs1_i,
                vs2:  issue_vs2_i
            };
        end
        for (int i = 0; i < NrIds; i++) busy_d[i] = entry_d[i].busy;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entry_q      <= '0;
            idle_q       <= 1'b1;
            retire_err_q <= 1'b0;
        end else begin
            entry_q      <= entry_d;
            idle_q       <= ~|busy_d;
            retire_err_q <= retire_err_d;
        end
    end

    assign busy_o       = busy;
    assign idle_o       = idle_q;
    assign retire_err_o = retire_err_q;

endmodule

// File: tb/tb_spatz_issue_scoreboard.sv
// Directed bench for spatz_issue_scoreboard: stimulus queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_spatz_issue_scoreboard;
    import spatz_pkg::*;

    typedef enum int {F_READY, F_ID, F_BUSY, F_IDLE, F_ERR} field_e;

    typedef struct {
        string      name;
        int         cyc;
        field_e     fld;
        logic [3:0] val;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                issue_valid = 1'b0;
    logic                issue_ready;
    vreg_t               vs1 = '0, vs2 = '0, vd = '0;
    logic                use_vs1 = 1'b0, use_vs2 = 1'b0, use_vd = 1'b0, vd_is_src = 1'b0;
    spatz_id_t           issue_id;
    logic [2:0]          retire_valid = '0;
    spatz_id_t [2:0]     retire_id = '0;
    logic [3:0]          busy;
    logic                idle;
    logic                retire_err;

    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    exp_t exp_q[$];

    spatz_issue_scoreboard dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .issue_valid_i     (issue_valid),
        .issue_ready_o     (issue_ready),
        .issue_vs1_i       (vs1),
        .issue_vs2_i       (vs2),
        .issue_vd_i        (vd),
        .issue_use_vs1_i   (use_vs1),
        .issue_use_vs2_i   (use_vs2),
        .issue_use_vd_i    (use_vd),
        .issue_vd_is_src_i (vd_is_src),
        .issue_id_o        (issue_id),
        .retire_valid_i    (retire_valid),
        .retire_id_i       (retire_id),
        .busy_o            (busy),
        .idle_o            (idle),
        .retire_err_o      (retire_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] act;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            case (e.fld)
                F_READY: act = {3'b0, issue_ready};
                F_ID:    act = {2'b0, issue_id};
                F_BUSY:  act = busy;
                F_IDLE:  act = {3'b0, idle};
                default: act = {3'b0, retire_err};
            endcase
            checks++;
            if (e.cyc != cyc || act !== e.val)
                $display("FAIL %s cycle %0d: got %b expected %b", e.name, cyc, act, e.val);
            else
                passed++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input field_e f, input logic [3:0] v, input string n);
        exp_q.push_back('{name: n, cyc: cyc, fld: f, val: v});
    endtask

    task automatic payload(input logic u1, input int r1, input logic u2, input int r2,
                           input logic ud, input int rd, input logic dsrc);
        use_vs1 = u1; vs1 = vreg_t'(r1);
        use_vs2 = u2; vs2 = vreg_t'(r2);
        use_vd  = ud; vd  = vreg_t'(rd);
        vd_is_src = dsrc;
    endtask

    task automatic retire(input int port, input int id);
        retire_valid[port] = 1'b1;
        retire_id[port]    = spatz_id_t'(id);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (busy !== 4'b0000) $display("FAIL direct_reset_busy: got %b", busy);
        else passed++;
        checks++;
        if (idle !== 1'b1) $display("FAIL direct_reset_idle: got %b", idle);
        else passed++;
        expect_val(F_BUSY, 4'b0000, "reset_busy");
        expect_val(F_IDLE, 4'd1, "reset_idle");
        expect_val(F_READY, 4'd1, "reset_ready");
        expect_val(F_ID, 4'd0, "reset_id");
        expect_val(F_ERR, 4'd0, "reset_err");

        // Write v1, no sources
        payload(0, 0, 0, 0, 1, 1, 0); issue_valid = 1'b1;
        expect_val(F_READY, 4'd1, "first_ready");
        expect_val(F_ID, 4'd0, "first_id");
        tick(); issue_valid = 1'b0;
        expect_val(F_BUSY, 4'b0001, "first_busy");
        expect_val(F_IDLE, 4'd0, "first_idle");

        // RAW on v1, retire ID0 on VFU releases it
        payload(0, 0, 1, 1, 1, 2, 0); issue_valid = 1'b1;
        expect_val(F_READY, 4'd0, "raw_block");
        tick();
        retire(int'(RET_VFU), 0);
        expect_val(F_READY, 4'd0, "raw_retire_same_cycle");
        tick(); retire_valid = '0;
        expect_val(F_READY, 4'd1, "raw_released_ready");
        expect_val(F_ID, 4'd0, "raw_released_id");
        expect_val(F_BUSY, 4'b0000, "raw_released_busy");
        tick(); issue_valid = 1'b0;
        expect_val(F_BUSY, 4'b0001, "raw_accepted_busy");
        retire(int'(RET_VFU), 0);
        tick(); retire_valid = '0;
        expect_val(F_IDLE, 4'd1, "drain_idle");

        // Entry reads v3, writes v4
        payload(1, 3, 0, 0, 1, 4, 0); issue_valid = 1'b1;
        expect_val(F_ID, 4'd0, "warwaw_setup_id");
        tick();
        payload(0, 0, 0, 0, 1, 3, 0);
        expect_val(F_READY, 4'd0, "war_block");
        tick();
        payload(0, 0, 0, 0, 1, 4, 0);
        expect_val(F_READY, 4'd0, "waw_block");
        tick();
        payload(1, 6, 0, 0, 1, 5, 0);
        expect_val(F_READY, 4'd1, "hazard_free_ready");
        expect_val(F_ID, 4'd1, "hazard_free_id");
        tick();
        payload(0, 0, 0, 0, 1, 5, 1);
        expect_val(F_BUSY, 4'b0011, "hazard_free_busy");
        expect_val(F_READY, 4'd0, "raw_vd_src_block");
        tick(); issue_valid = 1'b0;
        retire(int'(RET_VFU), 0); retire(int'(RET_VLSU), 1);
        tick(); retire_valid = '0;
        expect_val(F_BUSY, 4'b0000, "dual_retire_busy");
        expect_val(F_ERR, 4'd0, "dual_retire_err");

        // Fill all four IDs with register-free instructions
        payload(0, 0, 0, 0, 0, 0, 0); issue_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_val(F_READY, 4'd1, "fill_ready");
            expect_val(F_ID, 4'(i), "fill_id");
            tick();
        end
        expect_val(F_READY, 4'd0, "full_ready");
        expect_val(F_BUSY, 4'b1111, "full_busy");
        tick();
        retire(int'(RET_VLSU), 2);
        expect_val(F_READY, 4'd0, "full_retire_same_cycle");
        tick(); retire_valid = '0;
        expect_val(F_READY, 4'd1, "reuse_ready");
        expect_val(F_ID, 4'd2, "reuse_id");
        expect_val(F_BUSY, 4'b1011, "reuse_busy");
        tick(); issue_valid = 1'b0;
        expect_val(F_BUSY, 4'b1111, "refill_busy");

        // Two ports retire ID1 together, then ID3 twice
        retire(int'(RET_VFU), 1); retire(int'(RET_VSLDU), 1);
        tick(); retire_valid = '0;
        expect_val(F_BUSY, 4'b1101, "same_id_busy");
        expect_val(F_ERR, 4'd0, "same_id_err");
        retire(int'(RET_VFU), 3);
        tick(); retire_valid = '0;
        expect_val(F_BUSY, 4'b0101, "retire3_busy");
        retire(int'(RET_VFU), 3);
        tick(); retire_valid = '0;
        checks++;
        if (retire_err !== 1'b1) $display("FAIL direct_idle_retire_err: got %b", retire_err);
        else passed++;
        expect_val(F_ERR, 4'd1, "idle_retire_err");
        expect_val(F_BUSY, 4'b0101, "idle_retire_busy");
        tick();
        expect_val(F_ERR, 4'd0, "idle_retire_err_clear");

        // Third busy entry, then reset mid-operation
        issue_valid = 1'b1;
        expect_val(F_ID, 4'd1, "third_id");
        tick(); issue_valid = 1'b0;
        expect_val(F_BUSY, 4'b0111, "three_busy");
        rst = 1'b1;
        tick(); rst = 1'b0;
        checks++;
        if (busy !== 4'b0000) $display("FAIL direct_midreset_busy: got %b", busy);
        else passed++;
        checks++;
        if (idle !== 1'b1) $display("FAIL direct_midreset_idle: got %b", idle);
        else passed++;
        expect_val(F_BUSY, 4'b0000, "midreset_busy");
        expect_val(F_IDLE, 4'd1, "midreset_idle");
        retire(int'(RET_VFU), 0);
        tick(); retire_valid = '0;
        expect_val(F_ERR, 4'd1, "post_reset_retire_err");
        tick();
        expect_val(F_ERR, 4'd0, "post_reset_err_clear");
        tick(); tick();

        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            $display("FAIL %s: never compared, expected %b", e.name, e.val);
        end
        if (passed != checks) $display("FAIL summary: %0d of %0d checks failed", checks - passed, checks);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/spatz_issue_scoreboard.md
# spatz_issue_scoreboard

Issue scoreboard between the Spatz decoder and the execution units (VFU, VLSU, VSLDU). Allocates instruction IDs from a pool of `NrParallelInstructions`, records each in-flight instruction's vector register usage, and blocks issue on RAW/WAW/WAR hazards. Frees the ID when the owning unit reports completion.

## Interface
Parameters:
- `NrIds`, default `spatz_pkg::NrParallelInstructions` (4): number of IDs and entries.
- `NrRetirePorts`, default 3: completion ports. Port 0 is VFU, 1 is VLSU, 2 is VSLDU.

Ports. Clock and reset come first. There is one clock; reset is synchronous and active-high.
- `clk_i  in  1`  clock.
- `rst_i  in  1`  synchronous active-high reset.
- `issue_valid_i  in  1`  decoder presents an instruction.
- `issue_ready_o  out  1`  instruction accepted this cycle if valid.
- `issue_vs1_i, issue_vs2_i, issue_vd_i  in  vreg_t (5)`  register specifiers.
- `issue_use_vs1_i, issue_use_vs2_i, issue_use_vd_i, issue_vd_is_src_i  in  1 each`  usage flags.
- `issue_id_o  out  spatz_id_t (2)`  ID assigned to the presented instruction.
- `retire_valid_i  in  NrRetirePorts`  completion strobe per unit.
- `retire_id_i  in  NrRetirePorts x spatz_id_t`  completing ID per port.
- `busy_o  out  NrIds`  entry-valid vector.
- `idle_o  out  1`  no entry busy.
- `retire_err_o  out  1`  one-cycle pulse: a retire targeted a non-busy ID.

## Operation
Entry state per ID:
- `busy`.
- `vd` plus `wr` (the entry writes vd).
- `vs1`/`vs2`/`vd` source flags `rd1`, `rd2`, `rdd`.

Source set of an instruction:
- vs1 if `use_vs1`.
- vs2 if `use_vs2`.
- vd if `use_vd && vd_is_src`.

Hazard checks, each against every busy entry:
- RAW: entry `wr` and entry vd matches any new source.
- WAW: entry `wr`, new `use_vd`, and vds equal.
- WAR: new `use_vd` and new vd matches any entry source.

Issue and ID allocation:
- `free_any` is 1 when at least one entry is not busy.
- `issue_ready_o = free_any && !hazard`.
- `issue_id_o` is the lowest-index non-busy ID. It is 0 when none is free.
- Both outputs are functions of registered state and issue payload only. They never depend on `retire_*`.

Handshake:
- On `issue_valid_i && issue_ready_o`, entry `issue_id_o` is loaded with busy=1, vd, wr=`use_vd`, and the source flags.
- An instruction that uses no registers never hazards. It still needs a free ID.

Retire:
- For each port with `retire_valid_i`, clear `busy` of `retire_id_i`.
- Two ports retiring the same busy ID in one cycle free it once, with no error.
- A retire to a non-busy ID is ignored and pulses `retire_err_o` the next cycle.

Simultaneous events:
- Issue and retire in the same cycle are independent, because issue allocates a free ID and retire targets a busy one.
- A freed ID is not allocatable, and its hazards do not clear, until the following cycle.

Reset:
- All entries are cleared, so `busy_o=0` and `idle_o=1`.
- `issue_id_o=0` and `retire_err_o=0`.
- `issue_ready_o` reflects hazard-free with all IDs free, so it equals 1.
- Reset asserted mid-operation drops all in-flight entries at the next edge. Retires arriving afterwards for those IDs are flagged as errors.

## Timing
- Issue path: combinational from payload to `issue_ready_o`/`issue_id_o`, zero-cycle latency. The entry is visible in `busy_o` one cycle after the accepting edge.
- Retire path: the freed ID is visible one cycle after the strobe edge. Minimum ID reuse latency is 1 cycle after retire.
- Throughput: one issue per cycle while IDs are free and no hazard exists.
- Full: with NrIds entries busy, `issue_ready_o=0` regardless of hazards. `issue_valid_i` may be held; the payload must stay stable until accepted.
- `idle_o` and `busy_o` are registered.

## Structure
- Add to `spatz_pkg`:
  - `sb_entry_t`, a packed struct {busy, wr, rd1, rd2, rdd, vd, vs1, vs2}.
  - `retire_port_e` {RET_VFU, RET_VLSU, RET_VSLDU}.
- Reuse `spatz_id_t` and `vreg_t`.
- Lowest-free-ID search uses common_cells `lzc` on `~busy`.
- The per-entry hazard comparator is a natural sub-module, `spatz_sb_hazard_check`. It is purely combinational: one entry plus the issue payload in, raw/waw/war out. It is instantiated NrIds times.

## Test plan
- Reset, then issue vd=v1 with no sources → `issue_ready_o=1`, `issue_id_o=0`; next cycle `busy_o=4'b0001`, `idle_o=0`.
- RAW: after the previous case, issue vs2=v1, vd=v2 → ready=0. Retire ID 0 on the VFU port → next cycle ready=1 and `issue_id_o=0`.
- WAR/WAW: pending entry reading v3 and writing v4; new vd=v3 → blocked; new vd=v4 → blocked; new vd=v5 with source v6 → accepted with ID 1.
- Full: four hazard-free issues with IDs 0,1,2,3; fifth held with ready=0. Retire ID 2 on VLSU → next cycle ready=1, `issue_id_o=2`.
- Retire edge cases: VFU and VSLDU both retire ID 1 in the same cycle → `busy_o[1]` clears, no error. Retire of idle ID 3 → `retire_err_o` pulses for exactly one cycle.
- Reset mid-operation with 3 busy entries → next cycle `busy_o=0`, `idle_o=1`; a subsequent retire of ID 0 pulses `retire_err_o`.
